// File: rtl/pwm_compare_deadtime.sv
// pwm_compare_deadtime: carrier compare with shadowed compare value, complementary gate pair with dead-time, zero/period sync pulses
//   clk, reset        : clock, synchronous active-high reset
//   carrier, period   : carrier value and its period from the carrier generator
//   compare, load_mode: compare value and when it is copied into the active shadow
//   dead_time, pwm_en : dead band length in cycles, gate enable
//   pwm_h, pwm_l      : high/low side gates; cmp_shadow: active compare value
//   sync_zero/period  : one-cycle pulses on carrier zero/period entry
module pwm_compare_deadtime #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] carrier,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] compare,
    input  logic [1:0]       load_mode,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             pwm_en,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic [CNT_W-1:0] cmp_shadow,
    output logic             sync_zero,
    output logic             sync_period
);
    typedef enum logic [2:0] {OFF, H_ON, DT_H, L_ON, DT_L} state_t;
    state_t            state_q, state_d;
    logic [DT_W-1:0]   dt_q, dt_d;
    logic [CNT_W-1:0]  carrier_q, cmp_q;
    logic              raw_q, sync_zero_q, sync_period_q;
    logic              zero_evt, period_evt, load, dt_zero;
    logic [DT_W-1:0]   dt_load;
    // Events fire only on entry, so a carrier dwelling at 0 or period pulses once.
    assign zero_evt   = (carrier == '0) && (carrier_q != '0);
    assign period_evt = (carrier == period) && (carrier_q != period);
    // Disabled outputs let the shadow track the register bank freely.
    assign load = !pwm_en || (load_mode == 2'd3) || ((load_mode != 2'd1) && zero_evt)
                  || ((load_mode != 2'd0) && period_evt);
    assign dt_zero = (dead_time == '0);
    assign dt_load = dead_time - DT_W'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            carrier_q     <= '0;
            cmp_q         <= '0;
            raw_q         <= 1'b0;
            sync_zero_q   <= 1'b0;
            sync_period_q <= 1'b0;
            state_q       <= OFF;
            dt_q          <= '0;
        end else begin
            carrier_q     <= carrier;
            cmp_q         <= load ? compare : cmp_q;
            raw_q         <= carrier < cmp_q;
            sync_zero_q   <= zero_evt;
            sync_period_q <= period_evt;
            state_q       <= state_d;
            dt_q          <= dt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        if (!pwm_en) begin
            state_d = OFF;
            dt_d    = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = raw_q ? (dt_zero ? H_ON : DT_H) : (dt_zero ? L_ON : DT_L);
                    dt_d    = dt_load;
                end
                L_ON: if (raw_q) begin
                    state_d = dt_zero ? H_ON : DT_H;
                    dt_d    = dt_load;
                end
                H_ON: if (!raw_q) begin
                    state_d = dt_zero ? L_ON : DT_L;
                    dt_d    = dt_load;
                end
                // A raw level that reverts before the dead band ends aborts back to the old side.
                DT_H: if (!raw_q) state_d = L_ON;
                      else if (dt_q == '0) state_d = H_ON;
                      else dt_d = dt_q - DT_W'(1);
                DT_L: if (raw_q) state_d = H_ON;
                      else if (dt_q == '0) state_d = L_ON;
                      else dt_d = dt_q - DT_W'(1);
                default: state_d = OFF;
            endcase
        end
    end
    assign pwm_h       = (state_q == H_ON);
    assign pwm_l       = (state_q == L_ON);
    assign cmp_shadow  = cmp_q;
    assign sync_zero   = sync_zero_q;
    assign sync_period = sync_period_q;
endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// tb_pwm_compare_deadtime: directed-vector bench for pwm_compare_deadtime
module tb_pwm_compare_deadtime;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] carrier, period, compare, cmp_shadow;
    logic [1:0]  load_mode;
    logic [9:0]  dead_time;
    logic        pwm_en, pwm_h, pwm_l, sync_zero, sync_period;

    pwm_compare_deadtime #(.CNT_W(16), .DT_W(10)) dut (
        .clk(clk), .reset(reset), .carrier(carrier), .period(period),
        .compare(compare), .load_mode(load_mode), .dead_time(dead_time),
        .pwm_en(pwm_en), .pwm_h(pwm_h), .pwm_l(pwm_l), .cmp_shadow(cmp_shadow),
        .sync_zero(sync_zero), .sync_period(sync_period)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, n_overlap = 0;
    int nh, nl, nd, nsz, nsp;
    logic        h_tr[0:127], sz_tr[0:127], sp_tr[0:127];
    logic [15:0] sh_tr[0:127];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int c);
        carrier = 16'(c);
        @(posedge clk);
        #1;
        if (pwm_h && pwm_l) n_overlap++;
    endtask

    task automatic clr();
        nh = 0; nl = 0; nd = 0; nsz = 0; nsp = 0;
    endtask

    task automatic rec(input int i);
        h_tr[i]  = pwm_h;
        sz_tr[i] = sync_zero;
        sp_tr[i] = sync_period;
        sh_tr[i] = cmp_shadow;
        nh  += int'(pwm_h);
        nl  += int'(pwm_l);
        nd  += int'(!pwm_h && !pwm_l);
        nsz += int'(sync_zero);
        nsp += int'(sync_period);
    endtask

    task automatic up_period(input int chg_at, input logic [15:0] c);
        clr();
        for (int i = 0; i <= 99; i++) begin
            if (i == chg_at) compare = c;
            cyc(i);
            rec(i);
        end
    endtask

    // One up-down turn with period 10: 0,0,1..9,10,10,9..1
    task automatic ud_turn(input int chg_at, input logic [15:0] c);
        clr();
        for (int i = 0; i < 22; i++) begin
            if (i == chg_at) compare = c;
            cyc(i < 2 ? 0 : i < 11 ? i - 1 : i < 13 ? 10 : 22 - i);
            rec(i);
        end
    endtask

    initial begin
        reset = 1'b1; pwm_en = 1'b1; period = 16'd99; compare = 16'd50;
        load_mode = 2'd0; dead_time = 10'd0; carrier = '0;
        cyc(0);
        check("rst_h", pwm_h, 0);
        check("rst_l", pwm_l, 0);
        check("rst_shadow", cmp_shadow, 0);
        for (int i = 1; i < 4; i++) cyc(i);
        check("rst_hold_h", pwm_h, 0);
        check("rst_hold_shadow", cmp_shadow, 0);
        check("rst_hold_sync", {sync_zero, sync_period}, 0);
        reset = 1'b0;

        up_period(-1, 0);
        up_period(-1, 0);
        up_period(-1, 0);
        check("dt0_h_cycles", nh, 50);
        check("dt0_l_cycles", nl, 50);
        check("dt0_h_at0", h_tr[0], 0);
        check("dt0_h_at1", h_tr[1], 1);
        check("dt0_sz_count", nsz, 1);
        check("dt0_sz_at0", sz_tr[0], 1);
        check("dt0_sp_count", nsp, 1);

        dead_time = 10'd5;
        up_period(-1, 0);
        up_period(-1, 0);
        check("dt5_h_cycles", nh, 45);
        check("dt5_l_cycles", nl, 45);
        check("dt5_dead_cycles", nd, 10);

        up_period(30, 16'd20);
        check("shadow_held", sh_tr[99], 50);
        check("shadow_held_h", nh, 45);
        up_period(-1, 0);
        check("shadow_at_zero", sh_tr[0], 20);
        check("cmp20_h_cycles", nh, 15);
        load_mode = 2'd3;
        up_period(30, 16'd70);
        check("imm_before", sh_tr[29], 20);
        check("imm_after", sh_tr[30], 70);
        up_period(-1, 0);
        check("cmp70_h_cycles", nh, 65);

        period = 16'd10; compare = 16'd4; load_mode = 2'd2; dead_time = 10'd0;
        ud_turn(-1, 0);
        ud_turn(5, 16'd7);
        check("ud_sz_count", nsz, 1);
        check("ud_sp_count", nsp, 1);
        check("ud_sz_first0", sz_tr[0], 1);
        check("ud_sz_second0", sz_tr[1], 0);
        check("ud_sp_first10", sp_tr[11], 1);
        check("ud_sp_second10", sp_tr[12], 0);
        check("ud_shadow_pre_period", sh_tr[10], 4);
        check("ud_shadow_at_period", sh_tr[11], 7);
        ud_turn(15, 16'd3);
        check("ud_shadow_down_held", sh_tr[20], 7);
        ud_turn(-1, 0);
        check("ud_shadow_at_zero", sh_tr[0], 3);

        period = 16'd99; load_mode = 2'd3; dead_time = 10'd5; compare = 16'd0;
        up_period(-1, 0);
        up_period(-1, 0);
        check("cmp0_l_cycles", nl, 100);
        check("cmp0_h_cycles", nh, 0);
        compare = 16'd100;
        up_period(-1, 0);
        up_period(-1, 0);
        check("cmp100_h_cycles", nh, 100);
        compare = 16'd2;
        up_period(-1, 0);
        up_period(-1, 0);
        check("glitch_h_cycles", nh, 0);
        check("glitch_l_cycles", nl, 98);
        check("glitch_dead_cycles", nd, 2);

        compare = 16'd50;
        up_period(-1, 0);
        for (int i = 0; i <= 20; i++) cyc(i);
        check("pre_drop_h", pwm_h, 1);
        pwm_en = 1'b0; compare = 16'd33; load_mode = 2'd0;
        cyc(21);
        check("drop_outputs", {pwm_h, pwm_l}, 0);
        check("drop_shadow_follow", cmp_shadow, 33);
        pwm_en = 1'b1;
        clr();
        for (int i = 22; i <= 26; i++) begin
            cyc(i);
            rec(i);
        end
        check("enable_deadband", nd, 5);
        cyc(27);
        check("enable_h_on", pwm_h, 1);
        cyc(28);
        cyc(29);
        reset = 1'b1;
        cyc(30);
        check("midrun_rst_outputs", {pwm_h, pwm_l}, 0);
        check("midrun_rst_shadow", cmp_shadow, 0);
        check("midrun_rst_sync", {sync_zero, sync_period}, 0);
        reset = 1'b0;
        check("never_overlap", n_overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
